// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer: shift-add multiply, restoring divide, HI/LO write.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a one-cycle combinational product.
module muldiv_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             md_valid,
    input  logic             md_is_div,
    input  logic             md_signed,
    input  logic [WIDTH-1:0] md_src1,
    input  logic [WIDTH-1:0] md_src2,
    input  logic             md_cancel,
    output logic             md_ready,
    output logic             md_busy,
    output logic             hilo_we,
    output logic [WIDTH-1:0] hi_wdata,
    output logic [WIDTH-1:0] lo_wdata
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t             state_reg, state_next;
    logic [CW-1:0]      cnt_reg;
    logic               op_div_reg, neg_q_reg, neg_r_reg, div_zero_reg;
    logic [WIDTH-1:0]   opnd_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0]   hi_reg, lo_reg;

    logic               accept, last_iter, mul_last;
    logic               s1, s2;
    logic [WIDTH-1:0]   abs1, abs2;

    assign accept    = (state_reg == S_IDLE) && md_valid && !md_cancel;
    assign last_iter = (cnt_reg == CW'(WIDTH - 1));
    assign s1        = md_signed & md_src1[WIDTH-1];
    assign s2        = md_signed & md_src2[WIDTH-1];
    assign abs1      = s1 ? -md_src1 : md_src1;
    assign abs2      = s2 ? -md_src2 : md_src2;

    // Multiply: acc_reg = {partial product, remaining multiplier bits}, opnd_reg = multiplicand.
    logic [2*WIDTH-1:0] mul_acc_next;
`ifdef MULDIV_FAST_MUL_EN
    assign mul_acc_next = {{WIDTH{1'b0}}, opnd_reg} * {{WIDTH{1'b0}}, acc_reg[WIDTH-1:0]};
    assign mul_last     = 1'b1;
`else
    logic [WIDTH:0] mul_sum;
    assign mul_sum      = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                        + {1'b0, {WIDTH{acc_reg[0]}} & opnd_reg};
    assign mul_acc_next = {mul_sum, acc_reg[WIDTH-1:1]};
    assign mul_last     = last_iter;
`endif

    // Divide: acc_reg = {remainder, dividend/quotient}, opnd_reg = divisor.
    // The shifted partial remainder needs WIDTH+1 bits; after a successful subtract it fits WIDTH.
    logic [WIDTH:0]     div_part;
    logic               div_ge;
    logic [WIDTH-1:0]   div_sub;
    logic [2*WIDTH-1:0] div_acc_next;
    assign div_part     = acc_reg[2*WIDTH-1:WIDTH-1];
    assign div_ge       = (div_part >= {1'b0, opnd_reg});
    assign div_sub      = div_part[WIDTH-1:0] - opnd_reg;
    assign div_acc_next = {(div_ge ? div_sub : div_part[WIDTH-1:0]), acc_reg[WIDTH-2:0], div_ge};

    // Sign fixup. A zero divisor leaves the quotient all ones; negating the remainder by the
    // dividend sign turns |src1| back into the original src1.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, fix_hi, fix_lo;
    assign prod_fix = neg_q_reg ? -acc_reg : acc_reg;
    assign quo_fix  = (neg_q_reg && !div_zero_reg) ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    assign rem_fix  = neg_r_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
    assign fix_hi   = op_div_reg ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign fix_lo   = op_div_reg ? quo_fix : prod_fix[WIDTH-1:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (accept) state_next = md_is_div ? S_DIV : S_MUL;
            S_MUL:  if (md_cancel) state_next = S_IDLE; else if (mul_last) state_next = S_FIX;
            S_DIV:  if (md_cancel) state_next = S_IDLE; else if (last_iter) state_next = S_FIX;
            S_FIX:  state_next = md_cancel ? S_IDLE : S_DONE;
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        md_ready = (state_reg == S_IDLE);
        md_busy  = 1'b0;
        hilo_we  = 1'b0;
        case (state_reg)
            S_IDLE:             md_busy = md_valid & ~md_cancel;
            S_MUL, S_DIV, S_FIX: md_busy = 1'b1;
            S_DONE:             hilo_we = ~md_cancel;
            default:            md_busy = 1'b0;
        endcase
        md_busy = md_busy & resetn;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_reg      <= '0;
            op_div_reg   <= 1'b0;
            neg_q_reg    <= 1'b0;
            neg_r_reg    <= 1'b0;
            div_zero_reg <= 1'b0;
            opnd_reg     <= '0;
            acc_reg      <= '0;
            hi_reg       <= '0;
            lo_reg       <= '0;
        end else if (accept) begin
            cnt_reg      <= '0;
            op_div_reg   <= md_is_div;
            neg_q_reg    <= s1 ^ s2;
            neg_r_reg    <= s1;
            div_zero_reg <= (md_src2 == '0);
            opnd_reg     <= md_is_div ? abs2 : abs1;
            acc_reg      <= {{WIDTH{1'b0}}, (md_is_div ? abs1 : abs2)};
        end else if (state_reg == S_MUL) begin
            acc_reg <= mul_acc_next;
            cnt_reg <= cnt_reg + CW'(1);
        end else if (state_reg == S_DIV) begin
            acc_reg <= div_acc_next;
            cnt_reg <= cnt_reg + CW'(1);
        end else if (state_reg == S_FIX && !md_cancel) begin
            hi_reg <= fix_hi;
            lo_reg <= fix_lo;
        end
    end

    assign hi_wdata = hi_reg;
    assign lo_wdata = lo_reg;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: arithmetic/timeline reference model checked every cycle,
// plus literal expectations for each directed operation.
module tb_muldiv_ctrl;
    localparam int WIDTH = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = WIDTH;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        md_valid = 1'b1;
    logic        md_is_div = 1'b0;
    logic        md_signed = 1'b0;
    logic [31:0] md_src1 = '0;
    logic [31:0] md_src2 = '0;
    logic        md_cancel = 1'b0;
    logic        md_ready, md_busy, hilo_we;
    logic [31:0] hi_wdata, lo_wdata;

    always #5 clk = ~clk;

    muldiv_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .resetn(resetn), .md_valid(md_valid), .md_is_div(md_is_div),
        .md_signed(md_signed), .md_src1(md_src1), .md_src2(md_src2), .md_cancel(md_cancel),
        .md_ready(md_ready), .md_busy(md_busy), .hilo_we(hilo_we),
        .hi_wdata(hi_wdata), .lo_wdata(lo_wdata)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    // Architectural result as {HI, LO}.
    function automatic logic [63:0] golden(input logic d, input logic s,
                                           input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb;
        longint      sa, sb;
        logic [31:0] q, r;
        if (!d) begin
            ea = s ? {{32{a[31]}}, a} : {32'b0, a};
            eb = s ? {{32{b[31]}}, b} : {32'b0, b};
            return ea * eb;
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    // Timeline model: an accepted op is busy for lat+1 cycles, writes in cycle lat+2.
    bit          m_active = 1'b0;
    int          m_age = 0;
    int          m_lat = 0;
    logic [63:0] m_res = '0;
    logic [31:0] m_hi = '0, m_lo = '0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_active <= 1'b0;
            m_hi     <= '0;
            m_lo     <= '0;
        end else if (!m_active) begin
            if (md_valid && !md_cancel) begin
                m_active <= 1'b1;
                m_age    <= 1;
                m_lat    <= md_is_div ? WIDTH : MUL_LAT;
                m_res    <= golden(md_is_div, md_signed, md_src1, md_src2);
            end
        end else if (md_cancel || m_age == m_lat + 2) begin
            m_active <= 1'b0;
        end else begin
            if (m_age == m_lat + 1) begin
                m_hi <= m_res[63:32];
                m_lo <= m_res[31:0];
            end
            m_age <= m_age + 1;
        end
    end

    logic exp_busy, exp_we;
    always @(negedge clk) begin
        exp_busy = resetn && (m_active ? (m_age <= m_lat + 1) : (md_valid && !md_cancel));
        exp_we   = m_active && (m_age == m_lat + 2) && !md_cancel;
        chk("cyc_ready", md_ready, !m_active);
        chk("cyc_busy", md_busy, exp_busy);
        chk("cyc_we", hilo_we, exp_we);
        chk("cyc_hi", hi_wdata, m_hi);
        chk("cyc_lo", lo_wdata, m_lo);
    end

    int cyc = 0, we_cnt = 0, we_last = 0, we_prev = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (hilo_we === 1'b1) begin
            we_cnt  <= we_cnt + 1;
            we_prev <= we_last;
            we_last <= cyc;
        end
    end

    // Called between edges with the DUT idle; returns one cycle after the write, DUT idle again.
    task automatic run_op(input string nm, input logic d, input logic s,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo);
        int lat;
        bit seen;
        lat = (d ? WIDTH : MUL_LAT) + 2;
        chk({nm, "_model"}, golden(d, s, a, b), {ehi, elo});
        md_valid = 1'b1; md_is_div = d; md_signed = s; md_src1 = a; md_src2 = b;
        #1;
        chk({nm, "_busy_accept"}, md_busy, 1'b1);
        @(posedge clk); #1;
        md_valid = 1'b0; md_is_div = ~d; md_signed = ~s;
        md_src1 = $urandom; md_src2 = $urandom;
        seen = 1'b0;
        for (int i = 1; i <= lat + 4 && !seen; i++) begin
            @(negedge clk);
            if (hilo_we === 1'b1) begin
                seen = 1'b1;
                chk({nm, "_we_cycle"}, i, lat);
                chk({nm, "_hi"}, hi_wdata, ehi);
                chk({nm, "_lo"}, lo_wdata, elo);
            end else if (i <= lat - 1) begin
                chk({nm, "_busy_run"}, md_busy, 1'b1);
            end
        end
        chk({nm, "_we_seen"}, seen, 1'b1);
        @(posedge clk); #1;
    endtask

    int  we_base;
    bit  seen;

    initial begin
        #2;
        chk("rst_ready", md_ready, 1'b1);
        chk("rst_busy", md_busy, 1'b0);
        chk("rst_we", hilo_we, 1'b0);
        chk("rst_hi", hi_wdata, 32'h0);
        chk("rst_lo", lo_wdata, 32'h0);
        @(posedge clk); #1;
        md_valid = 1'b0;
        resetn   = 1'b1;
        @(posedge clk); #1;

        run_op("multu_max", 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg", 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("mult_min_sq", 1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
        run_op("div_neg", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu", 1'b1, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("div_ovf", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        run_op("div_neg_by0", 1'b1, 1'b1, 32'hFFFF_FF00, 32'h0, 32'hFFFF_FF00, 32'hFFFF_FFFF);
        run_op("divu_by0", 1'b1, 1'b0, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF);

        // Cancel at iteration 10 of a DIV.
        we_base  = we_cnt;
        md_valid = 1'b1; md_is_div = 1'b1; md_signed = 1'b1;
        md_src1  = 32'hFFFF_FC18; md_src2 = 32'd3;
        @(posedge clk); #1;
        md_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        md_cancel = 1'b1;
        @(posedge clk); #1;
        md_cancel = 1'b0;
        #1;
        chk("cancel_ready", md_ready, 1'b1);
        chk("cancel_busy", md_busy, 1'b0);
        chk("cancel_hi_hold", hi_wdata, 32'h1234);
        chk("cancel_lo_hold", lo_wdata, 32'hFFFF_FFFF);
        chk("cancel_no_we", we_cnt, we_base);
        run_op("multu_after_cancel", 1'b0, 1'b0, 32'd6, 32'd7, 32'd0, 32'd42);

        // Back-to-back MULTUs with md_valid held high.
        we_base  = we_cnt;
        md_valid = 1'b1; md_is_div = 1'b0; md_signed = 1'b0;
        md_src1  = 32'd3; md_src2 = 32'd4;
        @(posedge clk); #1;
        md_src1 = 32'd5; md_src2 = 32'd6;
        seen = 1'b0;
        for (int i = 0; i < MUL_LAT + 10 && !seen; i++) begin
            @(negedge clk);
            if (md_ready === 1'b1) seen = 1'b1;
        end
        chk("b2b_idle_seen", seen, 1'b1);
        chk("b2b_first_lo", lo_wdata, 32'd12);
        @(posedge clk); #1;
        md_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < MUL_LAT + 10 && !seen; i++) begin
            @(negedge clk);
            if (hilo_we === 1'b1) seen = 1'b1;
        end
        chk("b2b_second_we_seen", seen, 1'b1);
        @(posedge clk); #1;
        chk("b2b_interval", we_last - we_prev, MUL_LAT + 3);
        chk("b2b_pulses", we_cnt - we_base, 2);
        chk("b2b_hi", hi_wdata, 32'd0);
        chk("b2b_lo", lo_wdata, 32'd30);

        // Asynchronous reset in the middle of a multiply.
        md_valid = 1'b1; md_is_div = 1'b0; md_signed = 1'b0;
        md_src1  = 32'hFFFF_FFFF; md_src2 = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        md_valid = 1'b0;
        #1;
        chk("rst_mid_busy_before", md_busy, 1'b1);
        resetn = 1'b0;
        #1;
        chk("rst_mid_busy", md_busy, 1'b0);
        chk("rst_mid_ready", md_ready, 1'b1);
        chk("rst_mid_we", hilo_we, 1'b0);
        chk("rst_mid_hi", hi_wdata, 32'h0);
        chk("rst_mid_lo", lo_wdata, 32'h0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        run_op("mult_after_reset", 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFF9);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
